// File: rtl/targ_fb_queue.sv
// targ_fb_queue: lossy feedback FIFO between the execution pipes and the
// target predictor's training port. Up to s_pipe_cnt resolved branches are
// enqueued per cycle in pipe-index order; whatever does not fit is dropped
// and counted in a saturating counter. One entry per cycle is presented on fb_*.
//
// Handshake: fb_valid is high whenever the FIFO holds an entry; the head is
// consumed on every rising clk edge where fb_valid && fb_ready. fb_valid never
// depends on fb_ready, and fb_* stay stable until the head is consumed or a
// flush/reset occurs. The res_* side has no back-pressure at all.
module targ_fb_queue #(
    parameter int s_pipe_cnt     = 3,
    parameter int table_cnt      = 2,
    parameter int addr_width     = 32,
    parameter int fifo_depth     = 8,
    parameter int drop_cnt_width = 16,
    localparam int table_width   = (table_cnt > 1) ? $clog2(table_cnt) : 1,
    localparam int ptr_width     = $clog2(fifo_depth),
    localparam int cnt_width     = ptr_width + 1
) (
    input  logic                                    clk,
    input  logic                                    rst,
    input  logic                                    en,
    input  logic                                    flush,
    input  logic [s_pipe_cnt-1:0]                   res_valid,
    input  logic [s_pipe_cnt-1:0][addr_width-1:0]   res_addr,
    input  logic [s_pipe_cnt-1:0][addr_width-1:0]   res_targ,
    input  logic [s_pipe_cnt-1:0][table_width-1:0]  res_table,
    output logic                                    fb_valid,
    input  logic                                    fb_ready,
    output logic [addr_width-1:0]                   fb_addr,
    output logic [addr_width-1:0]                   fb_targ,
    output logic [table_width-1:0]                  fb_table,
    output logic [cnt_width-1:0]                    count,
    output logic [drop_cnt_width-1:0]               drop_cnt
);

    localparam int drop_width = $clog2(s_pipe_cnt + 1);

    logic [addr_width-1:0]  mem_addr  [fifo_depth];
    logic [addr_width-1:0]  mem_targ  [fifo_depth];
    logic [table_width-1:0] mem_table [fifo_depth];

    logic [ptr_width-1:0]   head;
    logic [ptr_width-1:0]   tail;
    logic                   pop;
    logic [cnt_width-1:0]   avail;
    logic [cnt_width-1:0]   accepted;
    logic [drop_width-1:0]  dropped;
    logic [s_pipe_cnt-1:0]  wr_en;
    logic [ptr_width-1:0]   wr_idx [s_pipe_cnt];
    logic [drop_cnt_width:0] drop_sum;

    // Head entry drives the predictor directly; zeros when nothing is queued.
    assign fb_valid = (count != '0);
    assign pop      = fb_valid && fb_ready;
    assign fb_addr  = fb_valid ? mem_addr[head]  : '0;
    assign fb_targ  = fb_valid ? mem_targ[head]  : '0;
    assign fb_table = fb_valid ? mem_table[head] : '0;

    // Allocate tail slots to valid pipes oldest-first; a slot freed by this
    // cycle's pop is already counted as available.
    always_comb begin
        avail    = cnt_width'(fifo_depth) - count + cnt_width'(pop);
        accepted = '0;
        dropped  = '0;
        wr_en    = '0;
        for (int i = 0; i < s_pipe_cnt; i++) begin
            wr_idx[i] = tail + accepted[ptr_width-1:0];
            if (en && !flush && res_valid[i]) begin
                if (accepted < avail) begin
                    wr_en[i] = 1'b1;
                    accepted = accepted + cnt_width'(1);
                end else begin
                    dropped = dropped + drop_width'(1);
                end
            end
        end
        drop_sum = {1'b0, drop_cnt} + (drop_cnt_width + 1)'(dropped);
    end

    // Pointer and occupancy bookkeeping; flush empties the queue outright.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else if (flush) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (pop) begin
                head <= head + ptr_width'(1);
            end
            tail  <= tail + accepted[ptr_width-1:0];
            count <= count - cnt_width'(pop) + accepted;
        end
    end

    // Saturating drop counter; survives flush, cleared only by reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            drop_cnt <= '0;
        end else if (drop_sum[drop_cnt_width]) begin
            drop_cnt <= '1;
        end else begin
            drop_cnt <= drop_sum[drop_cnt_width-1:0];
        end
    end

    // Entry storage; contents are only observable through a valid head.
    always_ff @(posedge clk) begin
        for (int i = 0; i < s_pipe_cnt; i++) begin
            if (wr_en[i]) begin
                mem_addr[wr_idx[i]]  <= res_addr[i];
                mem_targ[wr_idx[i]]  <= res_targ[i];
                mem_table[wr_idx[i]] <= res_table[i];
            end
        end
    end

endmodule

// File: tb/tb_targ_fb_queue.sv
// tb_targ_fb_queue: directed and randomized checks of targ_fb_queue against a
// queue-based reference model of the feedback FIFO.
module tb_targ_fb_queue;
    localparam int np    = 3;
    localparam int aw    = 32;
    localparam int depth = 8;
    localparam int dw    = 4;
    localparam int dmax  = (1 << dw) - 1;

    logic                  clk = 1'b0;
    logic                  rst = 1'b0;
    logic                  en = 1'b0;
    logic                  flush = 1'b0;
    logic                  fb_ready = 1'b0;
    logic [np-1:0]         res_valid = '0;
    logic [np-1:0][aw-1:0] res_addr = '0;
    logic [np-1:0][aw-1:0] res_targ = '0;
    logic [np-1:0][0:0]    res_table = '0;
    logic                  fb_valid;
    logic [aw-1:0]         fb_addr;
    logic [aw-1:0]         fb_targ;
    logic [0:0]            fb_table;
    logic [3:0]            count;
    logic [dw-1:0]         drop_cnt;

    typedef struct packed {
        logic [aw-1:0] addr;
        logic [aw-1:0] targ;
        logic [0:0]    tbl;
    } ent_t;

    ent_t exp_q[$];
    int   raw_drops = 0;
    int   checks = 0;
    int   errors = 0;

    targ_fb_queue #(
        .s_pipe_cnt(np), .table_cnt(2), .addr_width(aw),
        .fifo_depth(depth), .drop_cnt_width(dw)
    ) dut (
        .clk(clk), .rst(rst), .en(en), .flush(flush),
        .res_valid(res_valid), .res_addr(res_addr), .res_targ(res_targ),
        .res_table(res_table), .fb_valid(fb_valid), .fb_ready(fb_ready),
        .fb_addr(fb_addr), .fb_targ(fb_targ), .fb_table(fb_table),
        .count(count), .drop_cnt(drop_cnt)
    );

    // clock / reset
    always #5 clk = ~clk;

    function automatic int exp_drop();
        return (raw_drops > dmax) ? dmax : raw_drops;
    endfunction

    // Advance one edge and apply the FIFO rules to the model: flush empties,
    // otherwise pop first and then accept valid pipes while room remains.
    task automatic step();
        bit   do_pop;
        ent_t e;
        do_pop = (exp_q.size() != 0) && fb_ready;
        @(posedge clk);
        #1;
        if (flush) begin
            exp_q.delete();
        end else begin
            if (do_pop) void'(exp_q.pop_front());
            if (en) begin
                for (int i = 0; i < np; i++) begin
                    if (res_valid[i]) begin
                        if (exp_q.size() < depth) begin
                            e.addr = res_addr[i];
                            e.targ = res_targ[i];
                            e.tbl  = res_table[i];
                            exp_q.push_back(e);
                        end else begin
                            raw_drops++;
                        end
                    end
                end
            end
        end
    endtask

    // driver: random payload on every pipe, chosen valid mask
    task automatic drive_random(input logic [np-1:0] v);
        res_valid = v;
        for (int i = 0; i < np; i++) begin
            res_addr[i]  = $urandom;
            res_targ[i]  = $urandom;
            res_table[i] = 1'($urandom_range(0, 1));
        end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        #3;
        checks++; if (fb_valid !== 1'b0) begin errors++; $display("FAIL reset_fb_valid got %0b want 0", fb_valid); end
        checks++; if (fb_addr !== '0) begin errors++; $display("FAIL reset_fb_addr got %h want 0", fb_addr); end
        checks++; if (fb_targ !== '0 || fb_table !== '0) begin errors++; $display("FAIL reset_fb_targ_table got %h/%0d want 0/0", fb_targ, fb_table); end
        checks++; if (count !== 4'd0 || drop_cnt !== '0) begin errors++; $display("FAIL reset_counts got %0d/%0d want 0/0", count, drop_cnt); end
        exp_q.delete();
        raw_drops = 0;
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic test_single_entry();
        en = 1'b1;
        fb_ready = 1'b1;
        res_valid = 3'b010;
        res_addr[1] = 32'h100;
        res_targ[1] = 32'h200;
        res_table[1] = 1'b1;
        step();
        res_valid = '0;
        checks++; if (fb_valid !== 1'b1 || fb_addr !== 32'h100 || fb_targ !== 32'h200 || fb_table !== 1'b1)
            begin errors++; $display("FAIL single_head got v=%0b %h/%h/%0d want 1 100/200/1", fb_valid, fb_addr, fb_targ, fb_table); end
        checks++; if (count !== 4'd1) begin errors++; $display("FAIL single_count got %0d want 1", count); end
        step();
        checks++; if (count !== 4'd0 || fb_valid !== 1'b0 || drop_cnt !== '0)
            begin errors++; $display("FAIL single_drain got count=%0d v=%0b drop=%0d want 0/0/0", count, fb_valid, drop_cnt); end
    endtask

    task automatic test_multi_pipe_order();
        logic [aw-1:0] want [3];
        want[0] = 32'hA0; want[1] = 32'hB0; want[2] = 32'hC0;
        fb_ready = 1'b1;
        res_valid = 3'b111;
        for (int i = 0; i < np; i++) begin
            res_addr[i] = want[i];
            res_targ[i] = $urandom;
        end
        step();
        res_valid = '0;
        for (int k = 0; k < 3; k++) begin
            checks++; if (fb_valid !== 1'b1 || fb_addr !== want[k])
                begin errors++; $display("FAIL order_%0d got v=%0b addr=%h want 1 %h", k, fb_valid, fb_addr, want[k]); end
            step();
        end
        checks++; if (count !== 4'd0) begin errors++; $display("FAIL order_empty got %0d want 0", count); end
    endtask

    task automatic test_overflow_and_full_pop();
        logic [aw-1:0] want[$];
        fb_ready = 1'b0;
        res_valid = 3'b111;
        for (int c = 0; c < 3; c++) begin
            for (int p = 0; p < np; p++) begin
                res_addr[p] = 32'h1000 + 32'(c * 16 + p);
                res_targ[p] = $urandom;
                if (!(c == 2 && p == 2)) want.push_back(32'h1000 + 32'(c * 16 + p));
            end
            step();
        end
        checks++; if (count !== 4'd8) begin errors++; $display("FAIL overflow_count got %0d want 8", count); end
        checks++; if (drop_cnt !== 4'd1) begin errors++; $display("FAIL overflow_drop got %0d want 1", drop_cnt); end
        // full FIFO, pop and two pipes: only pipe 0 fits
        fb_ready = 1'b1;
        res_valid = 3'b011;
        res_addr[0] = 32'h2000;
        res_addr[1] = 32'h2001;
        void'(want.pop_front());
        want.push_back(32'h2000);
        step();
        res_valid = '0;
        checks++; if (count !== 4'd8) begin errors++; $display("FAIL fullpop_count got %0d want 8", count); end
        checks++; if (drop_cnt !== 4'd2) begin errors++; $display("FAIL fullpop_drop got %0d want 2", drop_cnt); end
        for (int k = 0; k < 8; k++) begin
            checks++; if (fb_addr !== want[k] || fb_valid !== 1'b1)
                begin errors++; $display("FAIL drain_%0d got v=%0b addr=%h want 1 %h", k, fb_valid, fb_addr, want[k]); end
            step();
        end
        checks++; if (fb_valid !== 1'b0) begin errors++; $display("FAIL drain_done got %0b want 0", fb_valid); end
    endtask

    task automatic test_flush_en();
        fb_ready = 1'b0;
        drive_random(3'b111); step();
        drive_random(3'b011); step();
        checks++; if (count !== 4'd5) begin errors++; $display("FAIL flush_fill got %0d want 5", count); end
        flush = 1'b1;
        drive_random(3'b111);
        step();
        flush = 1'b0;
        checks++; if (count !== 4'd0 || fb_valid !== 1'b0) begin errors++; $display("FAIL flush_empty got count=%0d v=%0b want 0/0", count, fb_valid); end
        checks++; if (drop_cnt !== 4'd2) begin errors++; $display("FAIL flush_drop got %0d want 2", drop_cnt); end
        en = 1'b0;
        fb_ready = 1'b1;
        for (int k = 0; k < 2; k++) begin
            drive_random(3'b111);
            step();
            checks++; if (count !== 4'd0 || drop_cnt !== 4'd2) begin errors++; $display("FAIL en_off_%0d got count=%0d drop=%0d want 0/2", k, count, drop_cnt); end
        end
        en = 1'b1;
        fb_ready = 1'b0;
        drive_random(3'b111);
        step();
        en = 1'b0;
        fb_ready = 1'b1;
        for (int k = 2; k >= 0; k--) begin
            drive_random(3'b111);
            step();
            checks++; if (count !== 4'(k)) begin errors++; $display("FAIL en_off_drain got %0d want %0d", count, k); end
        end
        en = 1'b1;
        res_valid = '0;
    endtask

    task automatic test_random();
        ent_t h;
        for (int n = 0; n < 400; n++) begin
            en = ($urandom_range(0, 7) != 0);
            flush = ($urandom_range(0, 31) == 0);
            fb_ready = ($urandom_range(0, 4) < 2);
            drive_random(np'($urandom_range(0, 7)));
            step();
            h = (exp_q.size() != 0) ? exp_q[0] : '0;
            checks++; if (fb_valid !== (exp_q.size() != 0)) begin errors++; $display("FAIL rand_valid@%0d got %0b want %0b", n, fb_valid, exp_q.size() != 0); end
            checks++; if (fb_addr !== h.addr || fb_targ !== h.targ || fb_table !== h.tbl)
                begin errors++; $display("FAIL rand_head@%0d got %h/%h/%0d want %h/%h/%0d", n, fb_addr, fb_targ, fb_table, h.addr, h.targ, h.tbl); end
            checks++; if (count !== 4'(exp_q.size())) begin errors++; $display("FAIL rand_count@%0d got %0d want %0d", n, count, exp_q.size()); end
            checks++; if (drop_cnt !== dw'(exp_drop())) begin errors++; $display("FAIL rand_drop@%0d got %0d want %0d", n, drop_cnt, exp_drop()); end
        end
        flush = 1'b0;
        en = 1'b1;
        res_valid = '0;
    endtask

    task automatic test_drop_sat_async_reset();
        int need;
        rst = 1'b0;
        exp_q.delete();
        raw_drops = 0;
        @(negedge clk);
        rst = 1'b1;
        fb_ready = 1'b0;
        drive_random(3'b111); step();
        drive_random(3'b111); step();
        drive_random(3'b011); step();
        while (raw_drops < 20) begin
            need = 20 - raw_drops;
            drive_random(np'((1 << ((need > 3) ? 3 : need)) - 1));
            step();
            checks++; if (drop_cnt !== dw'(exp_drop())) begin errors++; $display("FAIL sat_step got %0d want %0d", drop_cnt, exp_drop()); end
        end
        res_valid = '0;
        checks++; if (drop_cnt !== 4'd15 || count !== 4'd8) begin errors++; $display("FAIL sat_hold got drop=%0d count=%0d want 15/8", drop_cnt, count); end
        @(posedge clk);
        #2;
        rst = 1'b0;
        #1;
        checks++; if (count !== 4'd0 || drop_cnt !== '0 || fb_valid !== 1'b0 || fb_addr !== '0)
            begin errors++; $display("FAIL async_reset got count=%0d drop=%0d v=%0b addr=%h want 0/0/0/0", count, drop_cnt, fb_valid, fb_addr); end
        exp_q.delete();
        raw_drops = 0;
        @(negedge clk);
        rst = 1'b1;
    endtask

    initial begin
        test_reset();
        test_single_entry();
        test_multi_pipe_order();
        test_overflow_and_full_pop();
        test_flush_en();
        test_random();
        test_drop_sat_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
